spi_reg_ctrl: RTL and testbench

- Command/register-access controller sitting between the SPI slave byte interface and a bank of on-chip control/status registers.
- Parses framed SPI transactions: first byte after SS falls is a command (R/W + 7-bit address); subsequent bytes are write data or read data.
- Auto-increments the address per byte.
- Sequences register-bank read/write strobes and keeps the SPI transmit byte stable and prefetched.

---
 rtl/spi_reg_ctrl_if.sv | 38 +++
 rtl/spi_reg_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: SPI byte-side and register-bank-side signals of spi_reg_ctrl.
// access_err is present only when SPI_REG_CTRL_RANGE_CHK_EN is defined.
interface spi_reg_ctrl_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              ss;
    logic              rx_byte_available;
    logic [7:0]        rx_byte;
    logic              tx_byte_ready_to_write;
    logic [7:0]        tx_byte;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              busy;
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
    logic              access_err;

    modport master (
        input  ss, rx_byte_available, rx_byte, tx_byte_ready_to_write, reg_rdata,
        output tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, access_err
    );
    modport slave (
        output ss, rx_byte_available, rx_byte, tx_byte_ready_to_write, reg_rdata,
        input  tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy, access_err
    );
`else
    modport master (
        input  ss, rx_byte_available, rx_byte, tx_byte_ready_to_write, reg_rdata,
        output tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
    modport slave (
        output ss, rx_byte_available, rx_byte, tx_byte_ready_to_write, reg_rdata,
        input  tx_byte, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
`endif
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: framed SPI command parser driving register-bank writes and prefetched burst reads.
// Define SPI_REG_CTRL_RANGE_CHK_EN to suppress accesses at reg_addr >= NUM_REGS and report access_err.
module spi_reg_ctrl #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned NUM_REGS = 128
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_reg_ctrl_if.master bus
);
    localparam int unsigned       BYTE_W  = 8;
    localparam logic [BYTE_W-1:0] TX_IDLE = 8'h00;

    if (ADDR_W != 7 || NUM_REGS == 0 || NUM_REGS > 128) begin : g_cfg_check
        $error("spi_reg_ctrl: ADDR_W must be 7 and NUM_REGS within 1..128");
    end

`ifdef SPI_REG_CTRL_RANGE_CHK_EN
    localparam int unsigned       SPAN_W    = ADDR_W + 1;
    localparam logic [SPAN_W-1:0] REG_LIMIT = SPAN_W'(NUM_REGS);
    localparam logic [BYTE_W-1:0] TX_ERR    = 8'hFF;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;
    state_t state, state_d;

    logic              ss_meta, ss_sync, ss_prev, ss_fall, ss_rise;
    logic              rx_prev, tx_prev, rx_ev, tx_ev;
    logic [BYTE_W-1:0] rx_data;

    logic [BYTE_W-1:0] tx_byte_q, tx_byte_d, wdata_q, wdata_d, pf_buf, pf_buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, cmd_addr;
    logic              wr_q, wr_d, rd_q, rd_d, busy_q, busy_d;
    logic              pf_new, pf_new_d, first_pend, first_pend_d, wr_inc, wr_inc_d;
    logic              rd_req, rd_pend, rd_cap;
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
    logic              err_q, err_d, fetch_err_d, rd_pend_err, rd_cap_err;
`endif

    // ss synchronizer plus registered rising-edge detect of the byte strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta <= 1'b0;
            ss_sync <= 1'b0;
            ss_prev <= 1'b0;
            rx_prev <= 1'b0;
            tx_prev <= 1'b0;
            rx_ev   <= 1'b0;
            tx_ev   <= 1'b0;
            rx_data <= '0;
        end else begin
            ss_meta <= bus.ss;
            ss_sync <= ss_meta;
            ss_prev <= ss_sync;
            rx_prev <= bus.rx_byte_available;
            tx_prev <= bus.tx_byte_ready_to_write;
            rx_ev   <= bus.rx_byte_available & ~rx_prev;
            tx_ev   <= bus.tx_byte_ready_to_write & ~tx_prev;
            rx_data <= bus.rx_byte;
        end
    end

    assign ss_fall  = ss_prev & ~ss_sync;
    assign ss_rise  = ~ss_prev & ss_sync;
    assign addr_inc = addr_q + ADDR_W'(1);
    // command bits 1..7 carry the address MSB first
    assign cmd_addr = {rx_data[1], rx_data[2], rx_data[3], rx_data[4],
                       rx_data[5], rx_data[6], rx_data[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (ss_rise) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (ss_fall) state_d = CMD;
                CMD:     if (rx_ev) state_d = rx_data[0] ? READ : WRITE;
                WRITE:   ;
                READ:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_byte_d    = tx_byte_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = 1'b0;
        rd_d         = 1'b0;
        busy_d       = (state_d != IDLE);
        pf_buf_d     = pf_buf;
        pf_new_d     = 1'b0;
        first_pend_d = first_pend;
        wr_inc_d     = 1'b0;
        rd_req       = 1'b0;
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
        err_d        = 1'b0;
        fetch_err_d  = 1'b0;
`endif

        // read data lands one cycle after the strobe
        if (rd_cap) begin
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
            pf_buf_d = rd_cap_err ? TX_ERR : bus.reg_rdata;
`else
            pf_buf_d = bus.reg_rdata;
`endif
            pf_new_d = 1'b1;
        end

        if (wr_inc) addr_d = addr_inc;

        if (ss_rise) begin
            tx_byte_d    = TX_IDLE;
            first_pend_d = 1'b0;
        end else begin
            case (state)
                IDLE: if (ss_fall) tx_byte_d = TX_IDLE;
                CMD: if (rx_ev) begin
                    addr_d = cmd_addr;
                    if (rx_data[0]) begin
                        rd_req       = 1'b1;
                        first_pend_d = 1'b1;
                    end
                end
                WRITE: if (rx_ev) begin
                    wdata_d  = rx_data;
                    wr_inc_d = 1'b1;
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
                    if (addr_ok(addr_q)) wr_d = 1'b1;
                    else                 err_d = 1'b1;
`else
                    wr_d = 1'b1;
`endif
                end
                // tx_ev has priority; master dummy bytes (rx_ev) are ignored here
                READ: if (tx_ev || (first_pend && pf_new)) begin
                    tx_byte_d    = pf_buf;
                    addr_d       = addr_inc;
                    first_pend_d = 1'b0;
                    rd_req       = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_req) begin
`ifdef SPI_REG_CTRL_RANGE_CHK_EN
            rd_d        = addr_ok(addr_d);
            err_d       = ~addr_ok(addr_d);
            fetch_err_d = ~addr_ok(addr_d);
`else
            rd_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte_q  <= TX_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            pf_buf     <= '0;
            pf_new     <= 1'b0;
            first_pend <= 1'b0;
            wr_inc     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_cap     <= 1'b0;
        end else begin
            tx_byte_q  <= tx_byte_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            pf_buf     <= pf_buf_d;
            pf_new     <= pf_new_d;
            first_pend <= first_pend_d;
            wr_inc     <= wr_inc_d;
            rd_pend    <= rd_req;
            rd_cap     <= rd_pend;
        end
    end

`ifdef SPI_REG_CTRL_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= 1'b0;
            rd_pend_err <= 1'b0;
            rd_cap_err  <= 1'b0;
        end else begin
            err_q       <= err_d;
            rd_pend_err <= fetch_err_d;
            rd_cap_err  <= rd_pend_err;
        end
    end

    assign bus.access_err = err_q;
`endif

    assign bus.tx_byte   = tx_byte_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed checks of spi_reg_ctrl framing, burst write/read, wrap, abort and reset.
// With SPI_REG_CTRL_RANGE_CHK_EN defined the DUT is built with NUM_REGS=64 and range checks run.
module tb_spi_reg_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_reg_ctrl_if bus ();

`ifdef SPI_REG_CTRL_RANGE_CHK_EN
    spi_reg_ctrl #(.NUM_REGS(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    spi_reg_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_chk = 0;
    int n_bad = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_both = 0;
    int wr_base;
    logic [6:0] last_rd_addr = '0;
    logic [7:0] mem [128];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // register bank: read data valid the cycle after reg_rd
    always @(posedge clk) begin
        if (bus.reg_rd) bus.reg_rdata <= mem[bus.reg_addr];
    end

    always @(negedge clk) begin
        if (bus.reg_wr) n_wr++;
        if (bus.reg_rd) begin
            n_rd++;
            last_rd_addr = bus.reg_addr;
        end
        if (bus.reg_wr && bus.reg_rd) n_both++;
    end

    // wire-order {rw, addr} (MSB first on the wire) mapped so rx_byte[0] is the first wire bit
    function automatic logic [7:0] cmd(input logic rw, input logic [6:0] a);
        logic [7:0] w;
        logic [7:0] r;
        w = {rw, a};
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame(input string tag);
        bus.ss = 1'b0;
        tick(6);
        check({tag, "_busy_on"}, 32'(bus.busy), 32'd1);
        check({tag, "_tx_dummy"}, 32'(bus.tx_byte), 32'h00);
    endtask

    task automatic end_frame(input string tag);
        bus.ss = 1'b1;
        tick(6);
        check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
        check({tag, "_tx_idle"}, 32'(bus.tx_byte), 32'h00);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_byte_available = 1'b1;
        tick(4);
        bus.rx_byte_available = 1'b0;
        tick(4);
    endtask

    task automatic wr_byte(input string tag, input logic [6:0] a, input logic [7:0] d);
        bus.rx_byte = d;
        bus.rx_byte_available = 1'b1;
        @(negedge clk);
        check({tag, "_early"}, 32'(bus.reg_wr), 32'd0);
        @(negedge clk);
        check({tag, "_wr"}, 32'(bus.reg_wr), 32'd1);
        check({tag, "_addr"}, 32'(bus.reg_addr), 32'(a));
        check({tag, "_data"}, 32'(bus.reg_wdata), 32'(d));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus.reg_wr), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.rx_byte_available = 1'b0;
        tick(4);
    endtask

    task automatic tx_pulse(input string tag, input logic [7:0] old_b, input logic [7:0] new_b);
        bus.tx_byte_ready_to_write = 1'b1;
        @(negedge clk);
        check({tag, "_stable"}, 32'(bus.tx_byte), 32'(old_b));
        @(negedge clk);
        check({tag, "_next"}, 32'(bus.tx_byte), 32'(new_b));
        bus.tx_byte_ready_to_write = 1'b0;
        tick(4);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[7'h10] = 8'h11;
        mem[7'h11] = 8'h22;
        mem[7'h12] = 8'h33;

        rst_n = 1'b0;
        bus.ss = 1'b1;
        bus.rx_byte_available = 1'b0;
        bus.rx_byte = 8'h00;
        bus.tx_byte_ready_to_write = 1'b0;
        tick(2);
        check("rst_tx", 32'(bus.tx_byte), 32'h00);
        check("rst_addr", 32'(bus.reg_addr), 32'h00);
        check("rst_wdata", 32'(bus.reg_wdata), 32'h00);
        check("rst_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_rd", 32'(bus.reg_rd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick(4);

        // write burst at 5
        start_frame("wb");
        send_byte(cmd(1'b0, 7'd5));
        wr_byte("wb0", 7'd5, 8'hA5);
        wr_byte("wb1", 7'd6, 8'h3C);
        end_frame("wb");
        check("wb_count", 32'(n_wr), 32'd2);
        check("wb_no_rd", 32'(n_rd), 32'd0);

        // read burst at 0x10 with prefetch
        start_frame("rb");
        send_byte(cmd(1'b1, 7'h10));
        check("rb_first_tx", 32'(bus.tx_byte), 32'h11);
        check("rb_prefetch_rds", 32'(n_rd), 32'd2);
        check("rb_prefetch_addr", 32'(last_rd_addr), 32'h11);
        tx_pulse("rb_tx0", 8'h11, 8'h22);
        check("rb_refill_addr", 32'(last_rd_addr), 32'h12);
        check("rb_refill_rds", 32'(n_rd), 32'd3);
        send_byte(8'hEE);
        check("rb_dummy_no_wr", 32'(n_wr), 32'd2);
        check("rb_dummy_tx_hold", 32'(bus.tx_byte), 32'h22);
        tx_pulse("rb_tx1", 8'h22, 8'h33);
        end_frame("rb");

`ifndef SPI_REG_CTRL_RANGE_CHK_EN
        // address wrap 127 -> 0
        start_frame("wr");
        send_byte(cmd(1'b0, 7'd127));
        wr_byte("wrap0", 7'd127, 8'h01);
        wr_byte("wrap1", 7'd0, 8'h02);
        end_frame("wr");
`endif

        // abort mid-byte: no strobe for the partial byte
        start_frame("ab");
        send_byte(cmd(1'b0, 7'h20));
        wr_byte("ab0", 7'h20, 8'h55);
        wr_base = n_wr;
        end_frame("ab");
        check("ab_no_wr", 32'(n_wr), 32'(wr_base));

        // ss rise coinciding with rx_ev: no write
        start_frame("sim");
        send_byte(cmd(1'b0, 7'h21));
        wr_base = n_wr;
        bus.ss = 1'b1;
        @(negedge clk);
        bus.rx_byte = 8'h99;
        bus.rx_byte_available = 1'b1;
        tick(6);
        bus.rx_byte_available = 1'b0;
        tick(4);
        check("sim_no_wr", 32'(n_wr), 32'(wr_base));
        check("sim_busy", 32'(bus.busy), 32'd0);

        // asynchronous reset during a read frame
        start_frame("ar");
        send_byte(cmd(1'b1, 7'h10));
        check("ar_tx_before", 32'(bus.tx_byte), 32'h11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_tx", 32'(bus.tx_byte), 32'h00);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_addr", 32'(bus.reg_addr), 32'h00);
        check("ar_rd", 32'(bus.reg_rd), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        check("ar_stay_idle", 32'(bus.busy), 32'd0);
        bus.ss = 1'b1;
        tick(6);
        start_frame("ar2");
        send_byte(cmd(1'b0, 7'h30));
        wr_byte("ar2w", 7'h30, 8'h77);
        end_frame("ar2");

`ifdef SPI_REG_CTRL_RANGE_CHK_EN
        // out-of-range write and read at 70 with NUM_REGS=64
        start_frame("rcw");
        send_byte(cmd(1'b0, 7'd70));
        wr_base = n_wr;
        bus.rx_byte = 8'h5A;
        bus.rx_byte_available = 1'b1;
        tick(2);
        check("rcw_no_wr", 32'(bus.reg_wr), 32'd0);
        check("rcw_err", 32'(bus.access_err), 32'd1);
        tick(1);
        check("rcw_err_pulse", 32'(bus.access_err), 32'd0);
        bus.rx_byte_available = 1'b0;
        tick(4);
        check("rcw_wr_count", 32'(n_wr), 32'(wr_base));
        end_frame("rcw");

        start_frame("rcr");
        send_byte(cmd(1'b1, 7'd70));
        check("rcr_tx_ff", 32'(bus.tx_byte), 32'hFF);
        end_frame("rcr");
`endif

        check("wr_rd_exclusive", 32'(n_both), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
